// File: rtl/wb_trace_serializer.sv
// Commit-trace serializer: captures up to six writeback events per cycle from the
// dual-issue pipe and emits them one per cycle, in program order, from a FIFO.
module wb_trace_serializer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_we_a,
  input  logic [15:0]      mem_addr_a,
  input  logic [31:0]      mem_data_a,
  input  logic             reg_we_a,
  input  logic [4:0]       reg_waddr_a,
  input  logic [31:0]      reg_wdata_a,
  input  logic             hilo_we_a,
  input  logic [63:0]      hilo_a,
  input  logic             mem_we_b,
  input  logic [15:0]      mem_addr_b,
  input  logic [31:0]      mem_data_b,
  input  logic             reg_we_b,
  input  logic [4:0]       reg_waddr_b,
  input  logic [31:0]      reg_wdata_b,
  input  logic             hilo_we_b,
  input  logic [63:0]      hilo_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic [15:0]      out_addr,
  output logic [63:0]      out_data,
  output logic             stall_req,
  output logic             overflow,
  output logic [CNT_W-1:0] dropped_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0] KIND_MEM  = 2'd0;
  localparam logic [1:0] KIND_REG  = 2'd1;
  localparam logic [1:0] KIND_HILO = 2'd2;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]  kind_mem [DEPTH];
  logic [15:0] addr_mem [DEPTH];
  logic [63:0] data_mem [DEPTH];

  logic        ev_valid [6];
  logic [1:0]  ev_kind  [6];
  logic [15:0] ev_addr  [6];
  logic [63:0] ev_data  [6];
  logic [2:0]  ev_off   [6];
  logic [2:0]  k;

  logic          pop;
  logic [CW-1:0] free_slots;
  logic          accept;
  logic [CNT_W:0] drop_sum;

  // Events in fixed program order: MEM_A, REG_A, HILO_A, MEM_B, REG_B, HILO_B.
  always_comb begin
    ev_valid[0] = mem_we_a;
    ev_kind[0]  = KIND_MEM;
    ev_addr[0]  = mem_addr_a;
    ev_data[0]  = {32'b0, mem_data_a};
    ev_valid[1] = reg_we_a && (reg_waddr_a != 5'd0);
    ev_kind[1]  = KIND_REG;
    ev_addr[1]  = {11'b0, reg_waddr_a};
    ev_data[1]  = {32'b0, reg_wdata_a};
    ev_valid[2] = hilo_we_a;
    ev_kind[2]  = KIND_HILO;
    ev_addr[2]  = 16'b0;
    ev_data[2]  = hilo_a;
    ev_valid[3] = mem_we_b;
    ev_kind[3]  = KIND_MEM;
    ev_addr[3]  = mem_addr_b;
    ev_data[3]  = {32'b0, mem_data_b};
    ev_valid[4] = reg_we_b && (reg_waddr_b != 5'd0);
    ev_kind[4]  = KIND_REG;
    ev_addr[4]  = {11'b0, reg_waddr_b};
    ev_data[4]  = {32'b0, reg_wdata_b};
    ev_valid[5] = hilo_we_b;
    ev_kind[5]  = KIND_HILO;
    ev_addr[5]  = 16'b0;
    ev_data[5]  = hilo_b;
  end

  // Each qualified event's slot offset is the number of qualified events before it.
  always_comb begin
    k = 3'd0;
    for (int i = 0; i < 6; i++) begin
      ev_off[i] = k;
      k = k + {2'b0, ev_valid[i]};
    end
  end

  // Stream handshake: out_valid/out_* describe the head; a transfer happens on any
  // rising edge where out_valid && out_ready. While out_valid=1 and out_ready=0 the
  // head and every out_* field hold, and out_valid stays high.
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign free_slots = DEPTH_C - count + CW'(pop);
  assign accept     = (CW'(k) <= free_slots);
  assign stall_req  = ((DEPTH_C - count) < CW'(6));
  assign drop_sum   = {1'b0, dropped_cnt} + (CNT_W+1)'(k);

  // Fields read as zero while empty, so stale storage never shows after reset.
  assign out_kind = out_valid ? kind_mem[rd_ptr] : 2'b0;
  assign out_addr = out_valid ? addr_mem[rd_ptr] : 16'b0;
  assign out_data = out_valid ? data_mem[rd_ptr] : 64'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      dropped_cnt <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(k);
        count  <= count + CW'(k) - CW'(pop);
      end else begin
        count       <= count - CW'(pop);
        overflow    <= 1'b1;
        dropped_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int i = 0; i < 6; i++) begin
        if (ev_valid[i]) begin
          kind_mem[wr_ptr + AW'(ev_off[i])] <= ev_kind[i];
          addr_mem[wr_ptr + AW'(ev_off[i])] <= ev_addr[i];
          data_mem[wr_ptr + AW'(ev_off[i])] <= ev_data[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Bench for wb_trace_serializer: directed scenarios plus random traffic, checked by
// an event-queue reference model and a negedge monitor/scoreboard.
module tb_wb_trace_serializer;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_we_a, reg_we_a, hilo_we_a, mem_we_b, reg_we_b, hilo_we_b;
  logic [15:0] mem_addr_a, mem_addr_b;
  logic [31:0] mem_data_a, mem_data_b, reg_wdata_a, reg_wdata_b;
  logic [4:0]  reg_waddr_a, reg_waddr_b;
  logic [63:0] hilo_a, hilo_b;
  logic        out_valid, out_ready, stall_req, overflow;
  logic [1:0]  out_kind;
  logic [15:0] out_addr;
  logic [63:0] out_data;
  logic [CNT_W-1:0] dropped_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [81:0] exp_q[$];
  int          m_count = 0;
  logic        m_ovf = 1'b0;
  int          m_drop = 0;

  wb_trace_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a),
    .reg_we_a(reg_we_a), .reg_waddr_a(reg_waddr_a), .reg_wdata_a(reg_wdata_a),
    .hilo_we_a(hilo_we_a), .hilo_a(hilo_a),
    .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b),
    .reg_we_b(reg_we_b), .reg_waddr_b(reg_waddr_b), .reg_wdata_b(reg_wdata_b),
    .hilo_we_b(hilo_we_b), .hilo_b(hilo_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_addr(out_addr), .out_data(out_data), .stall_req(stall_req),
    .overflow(overflow), .dropped_cnt(dropped_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%h req=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic idle();
    mem_we_a = 0; reg_we_a = 0; hilo_we_a = 0;
    mem_we_b = 0; reg_we_b = 0; hilo_we_b = 0;
    mem_addr_a = 16'($urandom); mem_data_a = $urandom; reg_waddr_a = 5'($urandom);
    reg_wdata_a = $urandom; hilo_a = {$urandom, $urandom};
    mem_addr_b = 16'($urandom); mem_data_b = $urandom; reg_waddr_b = 5'($urandom);
    reg_wdata_b = $urandom; hilo_b = {$urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic set_all(input logic [7:0] tag);
    mem_we_a = 1; mem_addr_a = {8'h10, tag}; mem_data_a = {24'hA0A0A0, tag};
    reg_we_a = 1; reg_waddr_a = 5'd1 + 5'(tag[3:0]); reg_wdata_a = {24'hB0B0B0, tag};
    hilo_we_a = 1; hilo_a = {32'hC0C0C0C0, 24'h0, tag};
    mem_we_b = 1; mem_addr_b = {8'h20, tag}; mem_data_b = {24'hD0D0D0, tag};
    reg_we_b = 1; reg_waddr_b = 5'd17 + 5'(tag[3:0]); reg_wdata_b = {24'hE0E0E0, tag};
    hilo_we_b = 1; hilo_b = {32'hF0F0F0F0, 24'h0, tag};
  endtask

  task automatic rand_inputs(input int pct);
    idle();
    mem_we_a  = ($urandom_range(99) < pct);
    reg_we_a  = ($urandom_range(99) < pct);
    hilo_we_a = ($urandom_range(99) < pct);
    mem_we_b  = ($urandom_range(99) < pct);
    reg_we_b  = ($urandom_range(99) < pct);
    hilo_we_b = ($urandom_range(99) < pct);
    if ($urandom_range(3) == 0) reg_waddr_a = 5'd0;
    if ($urandom_range(3) == 0) reg_waddr_b = 5'd0;
  endtask

  task automatic chk_head(input string name, input logic [1:0] kind,
                          input logic [15:0] addr, input logic [63:0] data);
    chk({name, "_valid"}, 82'(out_valid), 82'(1));
    chk(name, {out_kind, out_addr, out_data}, {kind, addr, data});
  endtask

  // Reference model: list of qualified events, whole batch accepted or dropped.
  always @(posedge clk) begin
    logic [81:0] batch[$];
    int pop, free_n;
    if (rst) begin
      exp_q.delete();
      m_count = 0; m_ovf = 0; m_drop = 0;
    end else begin
      batch.delete();
      if (mem_we_a) batch.push_back({2'd0, mem_addr_a, 32'b0, mem_data_a});
      if (reg_we_a && reg_waddr_a != 0) batch.push_back({2'd1, 11'b0, reg_waddr_a, 32'b0, reg_wdata_a});
      if (hilo_we_a) batch.push_back({2'd2, 16'b0, hilo_a});
      if (mem_we_b) batch.push_back({2'd0, mem_addr_b, 32'b0, mem_data_b});
      if (reg_we_b && reg_waddr_b != 0) batch.push_back({2'd1, 11'b0, reg_waddr_b, 32'b0, reg_wdata_b});
      if (hilo_we_b) batch.push_back({2'd2, 16'b0, hilo_b});
      pop = (m_count != 0 && out_ready) ? 1 : 0;
      free_n = DEPTH - m_count + pop;
      if (batch.size() <= free_n) begin
        foreach (batch[i]) exp_q.push_back(batch[i]);
        m_count += batch.size();
      end else begin
        m_ovf = 1;
        m_drop = (m_drop + batch.size() > 65535) ? 65535 : m_drop + batch.size();
      end
      m_count -= pop;
    end
  end

  // Scoreboard monitor: compares status every cycle and the head on each transfer.
  logic        prev_stalled = 0;
  logic [81:0] prev_head;
  always @(negedge clk) begin
    logic [81:0] head, exp;
    if (!rst) begin
      head = {out_kind, out_addr, out_data};
      chk("out_valid", 82'(out_valid), 82'(m_count != 0));
      chk("stall_req", 82'(stall_req), 82'((DEPTH - m_count) < 6));
      chk("overflow", 82'(overflow), 82'(m_ovf));
      chk("dropped_cnt", 82'(dropped_cnt), 82'(m_drop));
      if (prev_stalled) begin
        chk("hold_valid", 82'(out_valid), 82'(1));
        chk("hold_head", head, prev_head);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", head, 82'(0) - 1);
        else begin
          exp = exp_q.pop_front();
          chk("out_event", head, exp);
        end
      end
      prev_stalled = out_valid && !out_ready;
      prev_head = head;
    end else begin
      prev_stalled = 0;
    end
  end

  // Stimulus
  initial begin
    idle();
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 82'(out_valid), 82'(0));
    chk("rst_stall", 82'(stall_req), 82'(0));
    chk("rst_ovf", 82'(overflow), 82'(0));
    chk("rst_drop", 82'(dropped_cnt), 82'(0));
    chk("rst_fields", {out_kind, out_addr, out_data}, 82'(0));
    rst = 0;

    // Mixed three-event batch
    mem_we_a = 1; mem_addr_a = 16'h0010; mem_data_a = 32'hDEADBEEF;
    reg_we_a = 1; reg_waddr_a = 5'd3; reg_wdata_a = 32'h12;
    hilo_we_b = 1; hilo_b = 64'h00000001_00000002;
    tick();
    chk_head("t1_mem", 2'd0, 16'h0010, 64'hDEADBEEF);
    tick();
    chk_head("t1_reg", 2'd1, 16'h0003, 64'h12);
    tick();
    chk_head("t1_hilo", 2'd2, 16'h0000, 64'h00000001_00000002);
    tick();
    chk("t1_empty", 82'(out_valid), 82'(0));

    // Write to $0 is not an event
    reg_we_a = 1; reg_waddr_a = 5'd0; reg_wdata_a = 32'h5555;
    reg_we_b = 1; reg_waddr_b = 5'd31; reg_wdata_b = 32'hFFFFFFFF;
    tick();
    chk_head("t2_reg31", 2'd1, 16'h001F, 64'hFFFFFFFF);
    tick();
    chk("t2_empty", 82'(out_valid), 82'(0));

    // Fill to 12 under backpressure; third full batch must be dropped whole
    out_ready = 0;
    set_all(8'h01); tick();
    set_all(8'h02); tick();
    chk("t3_stall", 82'(stall_req), 82'(1));
    set_all(8'h03); tick();
    chk("t3_ovf", 82'(overflow), 82'(1));
    chk("t3_drop", 82'(dropped_cnt), 82'(6));
    chk_head("t3_head", 2'd0, 16'h1001, 64'hA0A0A001);
    out_ready = 1;
    repeat (14) tick();
    chk("t3_empty", 82'(out_valid), 82'(0));

    // count=10 plus a 6-event batch with a same-cycle pop
    out_ready = 0;
    set_all(8'h04); tick();
    set_all(8'h05); reg_we_b = 0; hilo_we_b = 0; tick();
    out_ready = 1;
    set_all(8'h06); tick();
    chk("t4_stall", 82'(stall_req), 82'(1));
    chk("t4_drop", 82'(dropped_cnt), 82'(6));
    chk_head("t4_head", 2'd1, 16'(5'd5), 64'hB0B0B004);
    repeat (18) tick();
    chk("t4_empty", 82'(out_valid), 82'(0));

    // Alternating ready with one event per cycle
    for (int i = 0; i < 20; i++) begin
      reg_we_a = 1; reg_waddr_a = 5'(i % 31 + 1); reg_wdata_a = $urandom;
      out_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    idle();
    out_ready = 1;
    repeat (14) tick();
    chk("t5_empty", 82'(out_valid), 82'(0));

    // Mid-stream reset with 5 entries queued
    out_ready = 0;
    set_all(8'h07); hilo_we_b = 0; tick();
    rst = 1; set_all(8'h08);
    @(posedge clk); #1;
    rst = 0; idle();
    chk("t6_valid", 82'(out_valid), 82'(0));
    chk("t6_ovf", 82'(overflow), 82'(0));
    chk("t6_drop", 82'(dropped_cnt), 82'(0));
    chk("t6_fields", {out_kind, out_addr, out_data}, 82'(0));
    out_ready = 1;
    reg_we_a = 1; reg_waddr_a = 5'd7; reg_wdata_a = 32'h77;
    tick();
    chk_head("t6_reg", 2'd1, 16'h0007, 64'h77);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs((i < 200) ? 25 : 50);
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk); #1;
    end
    idle();
    out_ready = 1;
    repeat (DEPTH + 4) tick();
    chk("final_empty", 82'(exp_q.size()), 82'(0));
    chk("final_valid", 82'(out_valid), 82'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
